// File: rtl/onchip_mem_stream_reader_if.sv
// Bus bundle for the stream reader: Avalon-MM read side toward the on-chip memory
// and the Avalon-ST source toward the downstream consumer.
interface onchip_mem_stream_reader_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic [3:0]        mem_byteenable;
    logic [DATA_W-1:0] mem_writedata;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;

    logic [DATA_W-1:0] st_data;
    logic              st_valid;
    logic              st_ready;
    logic              st_sop;
    logic              st_eop;

    modport master (
        output mem_address, mem_chipselect, mem_write, mem_byteenable,
               mem_writedata, mem_clken,
        input  mem_readdata,
        output st_data, st_valid, st_sop, st_eop,
        input  st_ready
    );

    modport slave (
        input  mem_address, mem_chipselect, mem_write, mem_byteenable,
               mem_writedata, mem_clken,
        output mem_readdata,
        input  st_data, st_valid, st_sop, st_eop,
        output st_ready
    );
endinterface

// File: rtl/onchip_mem_stream_reader.sv
// Drains a contiguous word range from the on-chip memory into a credit-limited
// output FIFO and presents it as an Avalon-ST source with sop/eop framing.
//
// state  | meaning
// IDLE   | waiting for start; request fields latched on start
// RUN    | issuing reads while FIFO credit is available
// DRAIN  | all reads issued; waiting for returns and the last beat to leave
// DONE   | one-cycle completion pulse, then back to IDLE
module onchip_mem_stream_reader #(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 32,
    parameter int MEM_WORDS    = 12000,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    output logic              busy,
    output logic              done,
    output logic              error,
    onchip_mem_stream_reader_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 2;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                state, state_nxt;
    logic [ADDR_W-1:0]     addr_q, wc_q, issue_cnt, push_cnt;
    logic [READ_LATENCY-1:0] vld_sr;
    logic [DATA_W+1:0]     fifo_mem [FIFO_DEPTH];
    logic [DATA_W+1:0]     fifo_head;
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [PTR_W:0]        fifo_count;
    logic [CNT_W-1:0]      in_flight, credit_used;
    logic [ADDR_W:0]       end_addr;
    logic                  range_err, issue, push, pop, push_sop, push_eop;

    assign end_addr  = {1'b0, base_addr} + {1'b0, word_count};
    assign range_err = end_addr > (ADDR_W+1)'(MEM_WORDS);

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < READ_LATENCY; i++)
            in_flight = in_flight + CNT_W'(vld_sr[i]);
    end

    // Registered FIFO count: a pop this cycle frees its credit only next cycle.
    assign credit_used = CNT_W'(fifo_count) + in_flight;
    assign push        = vld_sr[READ_LATENCY-1];
    assign pop         = bus.st_valid & bus.st_ready;
    assign push_sop    = (push_cnt == '0);
    assign push_eop    = (push_cnt == wc_q - ADDR_W'(1));

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (word_count == '0 || range_err) state_nxt = S_DONE;
                    else                               state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (credit_used < CNT_W'(FIFO_DEPTH)) begin
                    issue = 1'b1;
                    if (issue_cnt + ADDR_W'(1) == wc_q) state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (vld_sr == '0 && fifo_count == (PTR_W+1)'(pop)) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            wc_q       <= '0;
            issue_cnt  <= '0;
            push_cnt   <= '0;
            vld_sr     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            error      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && start) begin
                addr_q    <= base_addr;
                wc_q      <= word_count;
                issue_cnt <= '0;
                push_cnt  <= '0;
                error     <= (word_count != '0) && range_err;
            end
            if (issue) begin
                addr_q    <= addr_q + ADDR_W'(1);
                issue_cnt <= issue_cnt + ADDR_W'(1);
            end
            vld_sr[0] <= issue;
            for (int i = 1; i < READ_LATENCY; i++)
                vld_sr[i] <= vld_sr[i-1];
            if (push) begin
                wr_ptr   <= wr_ptr + PTR_W'(1);
                push_cnt <= push_cnt + ADDR_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (PTR_W+1)'(1);
                2'b01:   fifo_count <= fifo_count - (PTR_W+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Framing flags travel with the data so they stay stable under backpressure.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= {push_sop, push_eop, bus.mem_readdata};
    end

    assign fifo_head = fifo_mem[rd_ptr];

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    assign bus.mem_address    = addr_q;
    assign bus.mem_chipselect = issue;
    assign bus.mem_write      = 1'b0;
    assign bus.mem_byteenable = 4'hF;
    assign bus.mem_writedata  = '0;
    assign bus.mem_clken      = 1'b1;

    assign bus.st_valid = (fifo_count != '0);
    assign bus.st_data  = fifo_head[DATA_W-1:0];
    assign bus.st_sop   = bus.st_valid & fifo_head[DATA_W+1];
    assign bus.st_eop   = bus.st_valid & fifo_head[DATA_W];
endmodule

// File: doc/onchip_mem_stream_reader.md
# onchip_mem_stream_reader

Avalon-MM read master that drains a contiguous word range out of the 32-bit single-port on-chip memory (12000 words, 14-bit word address, fixed read latency, no waitrequest) and presents it as an Avalon-ST source with backpressure. It is the reading-side counterpart to the memory's writers: software or a sequencer programs base/count, pulses `start`, and the block streams the words to a downstream consumer. A credit-limited output FIFO guarantees no returning read data is ever dropped.

## Interface

- `ADDR_W`, 14, memory word-address width
- `DATA_W`, 32, memory/stream data width
- `MEM_WORDS`, 12000, number of valid memory words
- `READ_LATENCY`, 1, cycles from address+chipselect to valid `mem_readdata`
- `FIFO_DEPTH`, 4, output FIFO entries (power of two, ≥ READ_LATENCY+2)

- `clk` in 1 — single clock for all logic
- `reset` in 1 — synchronous, active-high
- `start` in 1 — one-cycle request; sampled only in IDLE
- `base_addr` in ADDR_W — first word address, sampled with `start`
- `word_count` in ADDR_W — words to read, sampled with `start`
- `busy` out 1 — high whenever state ≠ IDLE
- `done` out 1 — one-cycle completion pulse
- `error` out 1 — range error flag of the last request
- `mem_address` out ADDR_W — read address
- `mem_chipselect` out 1 — read strobe, one word per high cycle
- `mem_write` out 1 — constant 0
- `mem_byteenable` out 4 — constant 4'hF
- `mem_writedata` out DATA_W — constant 0
- `mem_clken` out 1 — constant 1
- `mem_readdata` in DATA_W — read data, READ_LATENCY after strobe
- `st_data` out DATA_W, `st_valid` out 1, `st_ready` in 1, `st_sop` out 1, `st_eop` out 1 — Avalon-ST source

## Operation

- States: IDLE, RUN, DRAIN, DONE.
- IDLE: on `start`, latch `base_addr`/`word_count`, clear `error`. If `word_count`=0 → DONE, error=0. If `base_addr`+`word_count` > MEM_WORDS (compute at ADDR_W+1 bits) → DONE, error=1, no reads issued. Else → RUN.
- RUN: each cycle, issue one read (`mem_chipselect`=1, `mem_address`=current addr) iff fifo_count + outstanding < FIFO_DEPTH; addr increments by 1 per issue; issued counter increments. When issued = word_count after an issue → DRAIN.
- Outstanding tracked by a READ_LATENCY-deep valid shift register; return data written into FIFO in the cycle its valid bit emerges.
- DRAIN: no issues; → DONE when shift register empty, FIFO empty, and no beat being accepted is pending.
- DONE: `done`=1 for exactly this cycle, → IDLE. `error` holds until next accepted `start`.
- `start` while not IDLE: ignored, no side effect.
- Stream: `st_valid` = FIFO non-empty; pop on `st_valid & st_ready`. `st_sop` on first beat of a request, `st_eop` on beat number word_count. `st_data`/`st_sop`/`st_eop` stable while `st_valid & !st_ready`.
- Credit freed by a pop becomes usable the following cycle.
- Simultaneous FIFO push and pop: both performed, count unchanged.
- Address never wraps: range check prevents reaching MEM_WORDS.
- Reset mid-operation: state → IDLE, FIFO, counters, and valid shift register cleared; read data returning after reset discarded.

## Timing

- Reset values: `busy`=0, `done`=0, `error`=0, `mem_chipselect`=0, `mem_address`=0, `st_valid`=0, `st_sop`=0, `st_eop`=0; constants per Interface.
- `start` at cycle 0 → RUN in cycle 1, first `mem_chipselect` with `base_addr` in cycle 1.
- READ_LATENCY=1: data captured end of cycle 2, `st_valid` first high cycle 3.
- With `st_ready` held high and FIFO_DEPTH ≥ READ_LATENCY+2: one read per cycle, one beat per cycle.
- `done` asserted the cycle after the `st_eop` beat is accepted.
- Error/zero-count path: `done` (and `error` if range) in cycle 1, `busy` high only in cycle 1.
- FIFO never overflows under any `st_ready` pattern; at most FIFO_DEPTH words are buffered or in flight.

## Test plan

- base=0x0010, count=4, memory preloaded with 0xA0..0xA3, `st_ready`=1 → reads at 0x10..0x13 in cycles 1–4, beats 0xA0..0xA3 in cycles 3–6, sop on 0xA0, eop on 0xA3, `done` in cycle 7.
- Same request, `st_ready` low cycles 3–10 → chipselect stops after 4 words outstanding+buffered, no data lost, order intact, `st_data` stable while stalled.
- count=0 → `done`=1 cycle 1, `error`=0, no `mem_chipselect`, no beats.
- base=11998, count=3 → `done`=1 and `error`=1 in cycle 1, no reads; base=11997, count=3 → normal, last address 11999.
- `reset` asserted mid-RUN after 2 beats of 8 → next cycle all outputs at reset values; fresh request afterward streams correct data with sop on first beat.
- `start` pulsed again while busy → ignored; exactly word_count beats and one `done` produced.
